cmd_assembler: RTL and testbench
================================

CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 65535, meaning the max clocks allowed between the high-byte capture and the low-byte arrival (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rx_rdy  input  1  byte-available flag from the upstream UART receiver.
REQ-005 SHALL have port rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-006 SHALL have port clr_rx_rdy  output  1  one-cycle pulse acknowledging consumption of rx_data to the UART receiver.
REQ-007 SHALL have port clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-008 SHALL have port cmd_rdy  output  1  registered flag: a complete 16-bit command is held on cmd.
REQ-009 SHALL have port cmd  output  16  assembled command, {high byte, low byte}.
REQ-010 SHALL have port timeout_err  output  1  registered one-cycle pulse: a frame was abandoned after its high byte.

Function
REQ-011 SHALL implement a two-state machine: IDLE (awaiting high byte) and WAIT_LOW (awaiting low byte).
REQ-012 In IDLE with rx_rdy=1, SHALL latch rx_data into an internal high-byte register, drive clr_rx_rdy=1 in that same cycle, clear cmd_rdy at the next edge, and move to WAIT_LOW.
REQ-013 In WAIT_LOW with rx_rdy=1, SHALL load cmd <= {high byte, rx_data} and set cmd_rdy=1 at the next edge.
REQ-014 In that same WAIT_LOW cycle, SHALL drive clr_rx_rdy=1 and return to IDLE.
REQ-015 clr_rx_rdy SHALL be combinational from state and rx_rdy, asserted only in the capture cycles of REQ-012/013, and never asserted while rst=1.
REQ-016 Latency SHALL be exactly 1 clock from the low-byte capture cycle to cmd_rdy=1 with cmd valid.
REQ-017 cmd SHALL change only on low-byte capture; it holds its value across clr_cmd_rdy, timeouts, and high-byte captures.
REQ-018 cmd_rdy SHALL clear on clr_cmd_rdy=1 or on high-byte capture; if set (REQ-013) and clr_cmd_rdy coincide, set SHALL win.
REQ-019 SHALL keep a 16-bit timeout counter, held at 0 in IDLE and cleared on entry to WAIT_LOW.
REQ-020 The counter SHALL increment by 1 per clock in WAIT_LOW while rx_rdy=0.
REQ-021 In WAIT_LOW with rx_rdy=0 and counter==TIMEOUT_CLKS-1, SHALL return to IDLE, pulse timeout_err=1 for exactly one cycle at the next edge, discard the high byte, and leave cmd_rdy and cmd unchanged.
REQ-022 If rx_rdy=1 on the same cycle the counter reaches TIMEOUT_CLKS-1, the byte SHALL be accepted as the low byte (REQ-013) with no timeout_err.
REQ-023 The counter SHALL never wrap; it cannot exceed TIMEOUT_CLKS-1.
REQ-024 rx_rdy held high for several cycles without clearing SHALL be treated as one byte per capture cycle; each capture cycle asserts clr_rx_rdy.
REQ-025 Byte order SHALL be fixed: first byte after IDLE is cmd[15:8], second is cmd[7:0].

Reset
REQ-026 With rst=1 at a rising edge, SHALL set: state=IDLE, cmd=16'h0000, cmd_rdy=0, timeout_err=0, timeout counter=0, high-byte register=8'h00.
REQ-027 Reset asserted mid-frame (in WAIT_LOW) SHALL discard the partial frame; the first byte after rst deasserts SHALL be taken as a high byte.
REQ-028 While rst=1, all inputs SHALL be ignored and clr_rx_rdy SHALL be 0.

Verification
REQ-029 Bytes 8'hA5 then 8'h3C, each presented with rx_rdy for one cycle -> clr_rx_rdy pulses on both capture cycles; cmd=16'hA53C and cmd_rdy=1 one clock after the second capture.
REQ-030 cmd_rdy=1 with cmd=16'hA53C, then clr_cmd_rdy pulse -> cmd_rdy=0 next edge; cmd stays 16'hA53C.
REQ-031 TIMEOUT_CLKS=10, send 8'h12, then no byte -> timeout_err one-cycle pulse exactly 10 clocks after capture; state=IDLE; then 8'h34, 8'h56 -> cmd=16'h3456.
REQ-032 TIMEOUT_CLKS=10, low byte 8'h77 arrives on counter==9 -> cmd={high,8'h77}, cmd_rdy=1, no timeout_err.
REQ-033 clr_cmd_rdy asserted on the same cycle as low-byte capture -> cmd_rdy=1 after the edge.
REQ-034 rst=1 while in WAIT_LOW after 8'hFF -> after reset, cmd=16'h0000 and cmd_rdy=0; next 8'h01, 8'h02 -> cmd=16'h0102.

Source files
------------

// File: rtl/cmd_assembler.sv
`default_nettype none
// ============================================================================
// cmd_assembler: joins two UART bytes into a 16-bit command, high byte first,
// and abandons the frame if the low byte is late.   Rev 1.0
// ============================================================================
module cmd_assembler #(
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [15:0] cmd,
  output logic        timeout_err
);

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        clr_rx_rdy_w;

  always_comb begin
    state_d       = state_q;
    high_d        = high_q;
    cmd_d         = cmd_q;
    cmd_rdy_d     = cmd_rdy_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    clr_rx_rdy_w  = 1'b0;

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (rx_rdy) begin
          high_d       = rx_data;
          clr_rx_rdy_w = 1'b1;
          cmd_rdy_d    = 1'b0;
          state_d      = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A byte arriving on the last allowed cycle still completes the frame.
        if (rx_rdy) begin
          cmd_d        = {high_q, rx_data};
          cmd_rdy_d    = 1'b1;
          clr_rx_rdy_w = 1'b1;
          cnt_d        = 16'd0;
          state_d      = IDLE;
        end else if (cnt_q == C_TO_LAST) begin
          timeout_err_d = 1'b1;
          high_d        = 8'h00;
          cnt_d         = 16'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    if (rst) begin
      clr_rx_rdy_w = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      high_q        <= 8'h00;
      cmd_q         <= 16'h0000;
      cmd_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 16'd0;
    end else begin
      state_q       <= state_d;
      high_q        <= high_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign clr_rx_rdy  = clr_rx_rdy_w;
  assign cmd_rdy     = cmd_rdy_q;
  assign cmd         = cmd_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_assembler.sv
`default_nettype none
// ============================================================================
// tb_cmd_assembler: directed scenarios plus randomized traffic against a
// frame-level reference model.   Rev 1.0
// ============================================================================
module tb_cmd_assembler;

  localparam int TO = 10;

  logic        clk;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        timeout_err;

  cmd_assembler #(.TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Frame-level reference model
  logic        m_have;
  logic [7:0]  m_hb;
  int          m_wait;
  logic [15:0] m_cmd;
  logic        m_rdy;
  logic        m_err;
  logic        exp_clr;
  logic        act_clr;

  // Drives one clock of inputs, samples clr_rx_rdy mid-cycle, advances the model.
  task automatic step(input logic r, input logic rr, input logic [7:0] d, input logic cc);
    rst = r; rx_rdy = rr; rx_data = d; clr_cmd_rdy = cc;
    exp_clr = rr & ~r;
    #4;
    act_clr = clr_rx_rdy;
    @(posedge clk);
    m_err = 1'b0;
    if (r) begin
      m_have = 1'b0; m_hb = 8'h00; m_wait = 0; m_cmd = 16'h0000; m_rdy = 1'b0;
    end else begin
      if (cc) m_rdy = 1'b0;
      if (rr && !m_have) begin
        m_have = 1'b1; m_hb = d; m_wait = 0; m_rdy = 1'b0;
      end else if (rr) begin
        m_cmd = {m_hb, d}; m_rdy = 1'b1; m_have = 1'b0;
      end else if (m_have) begin
        m_wait++;
        if (m_wait == TO) begin
          m_have = 1'b0; m_err = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'h5C, 1'b0);
    checks++;
    if (act_clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", act_clr); end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cmd=%h rdy=%b err=%b want 0000/0/0", cmd, cmd_rdy, timeout_err);
    end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    checks++;
    if (act_clr !== 1'b1 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL basic_high got clr=%b rdy=%b want 1/0", act_clr, cmd_rdy);
    end
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    checks++;
    if (act_clr !== 1'b1 || cmd !== 16'hA53C || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_low got clr=%b cmd=%h rdy=%b want 1/a53c/1", act_clr, cmd, cmd_rdy);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C || act_clr !== 1'b0) begin
      errors++; $display("FAIL clear got rdy=%b cmd=%h clr=%b want 0/a53c/0", cmd_rdy, cmd, act_clr);
    end
  endtask

  task automatic test_timeout();
    step(1'b0, 1'b1, 8'h12, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (timeout_err !== (i == TO)) begin
        errors++; $display("FAIL timeout_pulse clk=%0d got %b want %b", i, timeout_err, (i == TO));
      end
    end
    checks++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL timeout_hold got cmd=%h rdy=%b want a53c/0", cmd, cmd_rdy);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_width got %b want 0", timeout_err); end
    step(1'b0, 1'b1, 8'h34, 1'b0);
    step(1'b0, 1'b1, 8'h56, 1'b0);
    checks++;
    if (cmd !== 16'h3456 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL timeout_recover got cmd=%h rdy=%b want 3456/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_late_low();
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL late_early_err clk=%0d got %b want 0", i, timeout_err); end
    end
    step(1'b0, 1'b1, 8'h77, 1'b0);
    checks++;
    if (act_clr !== 1'b1 || cmd !== 16'hC377 || cmd_rdy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL late_low got clr=%b cmd=%h rdy=%b err=%b want 1/c377/1/0", act_clr, cmd, cmd_rdy, timeout_err);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL late_after_err got %b want 0", timeout_err); end
  endtask

  task automatic test_set_wins();
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hC377) begin
      errors++; $display("FAIL setwin_high got rdy=%b cmd=%h want 0/c377", cmd_rdy, cmd);
    end
    step(1'b0, 1'b1, 8'h11, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h5A11) begin
      errors++; $display("FAIL setwin_low got rdy=%b cmd=%h want 1/5a11", cmd_rdy, cmd);
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hAB, 1'b0);
    checks++;
    if (act_clr !== 1'b0 || cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL midrst got clr=%b cmd=%h rdy=%b want 0/0000/0", act_clr, cmd, cmd_rdy);
    end
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    checks++;
    if (cmd !== 16'h0102 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL midrst_after got cmd=%h rdy=%b want 0102/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, d[i], 1'b0);
      checks++;
      if (act_clr !== 1'b1) begin errors++; $display("FAIL b2b_clr byte=%0d got %b want 1", i, act_clr); end
      if (i == 1 || i == 3) begin
        checks++;
        if (cmd !== {d[i-1], d[i]} || cmd_rdy !== 1'b1) begin
          errors++; $display("FAIL b2b_cmd byte=%0d got %h/%b want %h/1", i, cmd, cmd_rdy, {d[i-1], d[i]});
        end
      end else if (i == 2) begin
        checks++;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdyclr got %b want 0", cmd_rdy); end
      end
    end
  endtask

  task automatic test_random();
    int pr;
    logic r, rr, cc;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) pr = (n % 100 == 0) ? 60 : 4;
      r  = ($urandom_range(0, 99) < 2);
      rr = ($urandom_range(0, 99) < pr);
      cc = ($urandom_range(0, 99) < 15);
      step(r, rr, 8'($urandom), cc);
      checks++;
      if (act_clr !== exp_clr || cmd !== m_cmd || cmd_rdy !== m_rdy || timeout_err !== m_err) begin
        errors++;
        $display("FAIL rand n=%0d got clr=%b cmd=%h rdy=%b err=%b want %b/%h/%b/%b",
                 n, act_clr, cmd, cmd_rdy, timeout_err, exp_clr, m_cmd, m_rdy, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    m_have = 1'b0; m_hb = 8'h00; m_wait = 0; m_cmd = 16'h0000; m_rdy = 1'b0; m_err = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_clear();
    test_timeout();
    test_late_low();
    test_set_wins();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
